// File: rtl/redirect_collector_pkg.sv
// Shared types for the redirect collector slice.
//   rob_ptr_t  : ROB pointer (wrap flag + 5-bit index)
//   ftq_ptr_t  : FTQ pointer (wrap flag + 3-bit index)
//   redirect_t : one redirect record (ROB ptr, FTQ ptr, FTQ offset, target)
//   isOlder    : circular-pointer age compare; equal pointers are not older
package redirect_collector_pkg;

  localparam int unsigned VADDR_BITS = 39;

  typedef struct packed {
    logic       flag;
    logic [4:0] value;
  } rob_ptr_t;

  typedef struct packed {
    logic       flag;
    logic [2:0] value;
  } ftq_ptr_t;

  typedef struct packed {
    rob_ptr_t              rob_idx;
    ftq_ptr_t              ftq_idx;
    logic [2:0]            ftq_offset;
    logic [VADDR_BITS-1:0] target;
  } redirect_t;

  // Same wrap flag: smaller index is older. Different flags: the larger
  // index was allocated before the wrap, so it is the older one.
  function automatic logic isOlder(rob_ptr_t a, rob_ptr_t b);
    return (a.flag == b.flag) ? (a.value < b.value) : (a.value > b.value);
  endfunction

endpackage

// File: rtl/redirect_age_select.sv
// Combinational 2-input oldest-redirect selector.
//   cand_valid_0/1, cand_0/1 : candidate redirects from the two jump units
//   win_valid, win           : the oldest valid candidate (port 0 on a tie)
module redirect_age_select
  import redirect_collector_pkg::*;
(
  input  logic      cand_valid_0,
  input  redirect_t cand_0,
  input  logic      cand_valid_1,
  input  redirect_t cand_1,
  output logic      win_valid,
  output redirect_t win
);

  logic pick_1;

  always_comb begin
    // Port 1 only wins when strictly older, so equal ages favour port 0.
    pick_1    = cand_valid_1 & (~cand_valid_0 | isOlder(cand_1.rob_idx, cand_0.rob_idx));
    win_valid = cand_valid_0 | cand_valid_1;
    win       = pick_1 ? cand_1 : cand_0;
  end

endmodule

// File: rtl/redirect_collector.sv
// Collects mispredict redirects from two jump units into a single held
// redirect for the FTQ, keeping the oldest one and honouring ROB flushes.
//   clock, reset           : clock, asynchronous active-low reset
//   in_*_0 / in_*_1        : redirect inputs from jump units 0 and 1
//   flush_*                : ROB flush (kills entries equal-or-younger)
//   out_ready              : FTQ accepts the held redirect
//   out_valid, out_*       : held redirect, driven straight from flops
//   drop_count             : saturating count of dropped candidates
module redirect_collector
  import redirect_collector_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid_0,
  input  logic                  in_robIdx_flag_0,
  input  logic [4:0]            in_robIdx_value_0,
  input  logic                  in_ftqIdx_flag_0,
  input  logic [2:0]            in_ftqIdx_value_0,
  input  logic [2:0]            in_ftqOffset_0,
  input  logic [VADDR_BITS-1:0] in_target_0,
  input  logic                  in_isMisPred_0,
  input  logic                  in_valid_1,
  input  logic                  in_robIdx_flag_1,
  input  logic [4:0]            in_robIdx_value_1,
  input  logic                  in_ftqIdx_flag_1,
  input  logic [2:0]            in_ftqIdx_value_1,
  input  logic [2:0]            in_ftqOffset_1,
  input  logic [VADDR_BITS-1:0] in_target_1,
  input  logic                  in_isMisPred_1,
  input  logic                  flush_valid,
  input  logic                  flush_robIdx_flag,
  input  logic [4:0]            flush_robIdx_value,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic                  out_robIdx_flag,
  output logic [4:0]            out_robIdx_value,
  output logic                  out_ftqIdx_flag,
  output logic [2:0]            out_ftqIdx_value,
  output logic [2:0]            out_ftqOffset,
  output logic [VADDR_BITS-1:0] out_target,
  output logic [7:0]            drop_count
);

  redirect_t  cand_0, cand_1, win, hold_d, hold_q;
  rob_ptr_t   flush_rob;
  logic       cand_valid_0, cand_valid_1, win_valid;
  logic       hold_valid_d, hold_valid_q;
  logic       fire, hold_live, load;
  logic [1:0] n_drop;
  logic [8:0] drop_sum;
  logic [7:0] drop_count_d, drop_count_q;

  always_comb begin
    flush_rob = '{flag: flush_robIdx_flag, value: flush_robIdx_value};
    cand_0 = '{rob_idx:    '{flag: in_robIdx_flag_0, value: in_robIdx_value_0},
               ftq_idx:    '{flag: in_ftqIdx_flag_0, value: in_ftqIdx_value_0},
               ftq_offset: in_ftqOffset_0,
               target:     in_target_0};
    cand_1 = '{rob_idx:    '{flag: in_robIdx_flag_1, value: in_robIdx_value_1},
               ftq_idx:    '{flag: in_ftqIdx_flag_1, value: in_ftqIdx_value_1},
               ftq_offset: in_ftqOffset_1,
               target:     in_target_1};
    cand_valid_0 = in_valid_0 & in_isMisPred_0 &
                   ~(flush_valid & ~isOlder(cand_0.rob_idx, flush_rob));
    cand_valid_1 = in_valid_1 & in_isMisPred_1 &
                   ~(flush_valid & ~isOlder(cand_1.rob_idx, flush_rob));
  end

  redirect_age_select u_age_select (
    .cand_valid_0 (cand_valid_0),
    .cand_0       (cand_0),
    .cand_valid_1 (cand_valid_1),
    .cand_1       (cand_1),
    .win_valid    (win_valid),
    .win          (win)
  );

  always_comb begin
    // A firing hold leaves regardless of the flush; the flush then only
    // filters the candidates that may take its place.
    fire      = hold_valid_q & out_ready;
    hold_live = hold_valid_q & ~(flush_valid & ~isOlder(hold_q.rob_idx, flush_rob));
    load      = win_valid & (fire | ~hold_live | isOlder(win.rob_idx, hold_q.rob_idx));

    hold_valid_d = load | (hold_live & ~fire);
    hold_d       = load ? win : hold_q;

    // Every surviving candidate not loaded is a drop; load implies one exists.
    n_drop       = {1'b0, cand_valid_0} + {1'b0, cand_valid_1} - {1'b0, load};
    drop_sum     = {1'b0, drop_count_q} + {7'd0, n_drop};
    drop_count_d = drop_sum[8] ? '1 : drop_sum[7:0];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hold_valid_q <= 1'b0;
      hold_q       <= '0;
      drop_count_q <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_q       <= hold_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign out_valid        = hold_valid_q;
  assign out_robIdx_flag  = hold_q.rob_idx.flag;
  assign out_robIdx_value = hold_q.rob_idx.value;
  assign out_ftqIdx_flag  = hold_q.ftq_idx.flag;
  assign out_ftqIdx_value = hold_q.ftq_idx.value;
  assign out_ftqOffset    = hold_q.ftq_offset;
  assign out_target       = hold_q.target;
  assign drop_count       = drop_count_q;

endmodule

// File: tb/tb_redirect_collector.sv
module tb_redirect_collector;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid_0, in_robIdx_flag_0, in_ftqIdx_flag_0, in_isMisPred_0;
  logic [4:0]  in_robIdx_value_0;
  logic [2:0]  in_ftqIdx_value_0, in_ftqOffset_0;
  logic [38:0] in_target_0;
  logic        in_valid_1, in_robIdx_flag_1, in_ftqIdx_flag_1, in_isMisPred_1;
  logic [4:0]  in_robIdx_value_1;
  logic [2:0]  in_ftqIdx_value_1, in_ftqOffset_1;
  logic [38:0] in_target_1;
  logic        flush_valid, flush_robIdx_flag;
  logic [4:0]  flush_robIdx_value;
  logic        out_ready;
  logic        out_valid, out_robIdx_flag, out_ftqIdx_flag;
  logic [4:0]  out_robIdx_value;
  logic [2:0]  out_ftqIdx_value, out_ftqOffset;
  logic [38:0] out_target;
  logic [7:0]  drop_count;

  redirect_collector dut (
    .clock (clock), .reset (reset),
    .in_valid_0 (in_valid_0), .in_robIdx_flag_0 (in_robIdx_flag_0),
    .in_robIdx_value_0 (in_robIdx_value_0), .in_ftqIdx_flag_0 (in_ftqIdx_flag_0),
    .in_ftqIdx_value_0 (in_ftqIdx_value_0), .in_ftqOffset_0 (in_ftqOffset_0),
    .in_target_0 (in_target_0), .in_isMisPred_0 (in_isMisPred_0),
    .in_valid_1 (in_valid_1), .in_robIdx_flag_1 (in_robIdx_flag_1),
    .in_robIdx_value_1 (in_robIdx_value_1), .in_ftqIdx_flag_1 (in_ftqIdx_flag_1),
    .in_ftqIdx_value_1 (in_ftqIdx_value_1), .in_ftqOffset_1 (in_ftqOffset_1),
    .in_target_1 (in_target_1), .in_isMisPred_1 (in_isMisPred_1),
    .flush_valid (flush_valid), .flush_robIdx_flag (flush_robIdx_flag),
    .flush_robIdx_value (flush_robIdx_value), .out_ready (out_ready),
    .out_valid (out_valid), .out_robIdx_flag (out_robIdx_flag),
    .out_robIdx_value (out_robIdx_value), .out_ftqIdx_flag (out_ftqIdx_flag),
    .out_ftqIdx_value (out_ftqIdx_value), .out_ftqOffset (out_ftqOffset),
    .out_target (out_target), .drop_count (drop_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       v0, mp0; logic [5:0] r0;
    logic       v1, mp1; logic [5:0] r1;
    logic       fl;      logic [5:0] fr;
    logic       rdy;
    logic       e_valid; logic [5:0] e_rob; logic e_port; int e_drop;
  } vec_t;

  typedef struct {
    logic e_valid; logic [5:0] e_rob; logic e_port; int e_drop;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Payload fields are tagged with the source port so a wrong pick on an
  // equal-age tie shows up in the target/FTQ fields.
  function automatic logic [38:0] tgt(logic p, logic [5:0] r);
    return {18'h25A5A, p, 14'h0, r};
  endfunction
  function automatic logic [3:0] ftq(logic p, logic [5:0] r);
    return {p, r[2:0]};
  endfunction

  function automatic logic [5:0] R(logic f, int v);
    logic [5:0] t;
    t = {f, 5'(v)};
    return t;
  endfunction

  function automatic vec_t mk(logic v0, logic mp0, logic [5:0] r0,
                              logic v1, logic mp1, logic [5:0] r1,
                              logic fl, logic [5:0] fr, logic rdy,
                              logic ev, logic [5:0] erob, logic ep, int ed);
    vec_t v;
    v.v0 = v0; v.mp0 = mp0; v.r0 = r0; v.v1 = v1; v.mp1 = mp1; v.r1 = r1;
    v.fl = fl; v.fr = fr; v.rdy = rdy;
    v.e_valid = ev; v.e_rob = erob; v.e_port = ep; v.e_drop = ed;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [step %0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    in_valid_0 = v.v0; in_isMisPred_0 = v.mp0;
    {in_robIdx_flag_0, in_robIdx_value_0} = v.r0;
    {in_ftqIdx_flag_0, in_ftqIdx_value_0} = ftq(1'b0, v.r0);
    in_ftqOffset_0 = v.r0[5:3] ^ 3'd1;
    in_target_0 = tgt(1'b0, v.r0);
    in_valid_1 = v.v1; in_isMisPred_1 = v.mp1;
    {in_robIdx_flag_1, in_robIdx_value_1} = v.r1;
    {in_ftqIdx_flag_1, in_ftqIdx_value_1} = ftq(1'b1, v.r1);
    in_ftqOffset_1 = v.r1[5:3] ^ 3'd6;
    in_target_1 = tgt(1'b1, v.r1);
    flush_valid = v.fl;
    {flush_robIdx_flag, flush_robIdx_value} = v.fr;
    out_ready = v.rdy;
  endtask

  task automatic compare_out(input int idx);
    exp_t e;
    e = sb.pop_front();
    check("out_valid", idx, 64'(out_valid), 64'(e.e_valid));
    check("drop_count", idx, 64'(drop_count), 64'(e.e_drop));
    if (e.e_valid) begin
      check("out_robIdx", idx, 64'({out_robIdx_flag, out_robIdx_value}), 64'(e.e_rob));
      check("out_ftqIdx", idx, 64'({out_ftqIdx_flag, out_ftqIdx_value}), 64'(ftq(e.e_port, e.e_rob)));
      check("out_ftqOffset", idx, 64'(out_ftqOffset),
            64'(e.e_rob[5:3] ^ (e.e_port ? 3'd6 : 3'd1)));
      check("out_target", idx, 64'(out_target), 64'(tgt(e.e_port, e.e_rob)));
    end
  endtask

  // Called at a negedge: drive, queue expectation, sample 1 unit after posedge.
  task automatic apply(input vec_t v, input int idx);
    exp_t e;
    drive(v);
    e.e_valid = v.e_valid; e.e_rob = v.e_rob; e.e_port = v.e_port; e.e_drop = v.e_drop;
    sb.push_back(e);
    @(posedge clock);
    #1;
    compare_out(idx);
    @(negedge clock);
  endtask

  task automatic check_reset_state(input int idx);
    check("rst_out_valid", idx, 64'(out_valid), 64'd0);
    check("rst_drop_count", idx, 64'(drop_count), 64'd0);
    check("rst_robIdx", idx, 64'({out_robIdx_flag, out_robIdx_value}), 64'd0);
    check("rst_ftq", idx, 64'({out_ftqIdx_flag, out_ftqIdx_value, out_ftqOffset}), 64'd0);
    check("rst_target", idx, 64'(out_target), 64'd0);
  endtask

  initial begin
    vec_t idle;
    vec_t v;
    int   d;
    idle = mk(0,0,0, 0,0,0, 0,0, 0, 0,0,0, 0);
    drive(idle);

    //        v0 mp0 r0        v1 mp1 r1        fl fr       rdy  ev erob     ep drop
    tbl.push_back(mk(1,1,R(0,7),   0,0,0,         0,0,        0,   1,R(0,7), 0, 0));
    tbl.push_back(mk(0,0,0,        0,0,0,         0,0,        1,   0,0,      0, 0));
    tbl.push_back(mk(1,1,R(0,9),   1,1,R(0,4),    0,0,        0,   1,R(0,4), 1, 1));
    tbl.push_back(mk(0,0,0,        0,0,0,         0,0,        1,   0,0,      0, 1));
    tbl.push_back(mk(1,1,R(1,2),   0,0,0,         0,0,        0,   1,R(1,2), 0, 1));
    tbl.push_back(mk(0,0,0,        1,1,R(0,30),   0,0,        0,   1,R(0,30),1, 1));
    tbl.push_back(mk(1,1,R(1,5),   0,0,0,         0,0,        0,   1,R(0,30),1, 2));
    tbl.push_back(mk(0,0,0,        0,0,0,         0,0,        1,   0,0,      0, 2));
    tbl.push_back(mk(1,1,R(0,10),  0,0,0,         0,0,        0,   1,R(0,10),0, 2));
    tbl.push_back(mk(0,0,0,        0,0,0,         1,R(0,10),  0,   0,0,      0, 2));
    tbl.push_back(mk(1,1,R(0,10),  0,0,0,         0,0,        0,   1,R(0,10),0, 2));
    tbl.push_back(mk(0,0,0,        0,0,0,         1,R(0,11),  0,   1,R(0,10),0, 2));
    tbl.push_back(mk(0,0,0,        1,1,R(0,3),    0,0,        1,   1,R(0,3), 1, 2));
    tbl.push_back(mk(1,0,R(0,1),   1,0,R(0,0),    0,0,        0,   1,R(0,3), 1, 2));
    tbl.push_back(mk(1,1,R(0,5),   0,0,0,         1,R(0,8),   1,   1,R(0,5), 0, 2));
    tbl.push_back(mk(1,1,R(0,1),   1,1,R(0,6),    1,R(0,2),   1,   1,R(0,1), 0, 2));
    tbl.push_back(mk(1,1,R(0,3),   0,0,0,         1,R(0,0),   0,   0,0,      0, 2));
    tbl.push_back(mk(1,1,R(0,12),  1,1,R(0,12),   0,0,        0,   1,R(0,12),0, 3));
    tbl.push_back(mk(0,0,0,        0,0,0,         0,0,        1,   0,0,      0, 3));
    tbl.push_back(mk(1,0,R(0,0),   1,1,R(1,1),    0,0,        0,   1,R(1,1), 1, 3));
    tbl.push_back(mk(1,1,R(1,0),   1,1,R(1,1),    0,0,        0,   1,R(1,0), 0, 4));
    tbl.push_back(mk(0,0,0,        0,0,0,         0,0,        1,   0,0,      0, 4));
    tbl.push_back(mk(1,1,R(0,0),   0,0,0,         0,0,        0,   1,R(0,0), 0, 4));

    // Held in reset for a few edges: everything must read zero.
    repeat (3) @(posedge clock);
    #1;
    check_reset_state(0);
    @(negedge clock);
    reset = 1'b1;

    // First vector is captured on the very first edge after release.
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i + 1);

    // Two younger candidates per cycle against a stuck hold: drops saturate.
    d = 4;
    for (int i = 0; i < 150; i++) begin
      d = (d + 2 > 255) ? 255 : d + 2;
      v = mk(1,1,R(0,20), 1,1,R(0,21), 0,0, 0, 1,R(0,0), 0, d);
      apply(v, 100 + i);
    end
    check("drop_saturated", 300, 64'(drop_count), 64'd255);

    // Asynchronous reset mid-operation discards the hold immediately.
    drive(idle);
    #2;
    reset = 1'b0;
    #1;
    check_reset_state(301);
    @(negedge clock);
    reset = 1'b1;
    apply(mk(1,1,R(0,7),  0,0,0,       0,0, 0, 1,R(0,7),  0, 0), 302);
    apply(mk(0,0,0,       1,1,R(1,31), 0,0, 1, 1,R(1,31), 1, 0), 303);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    n_fail++;
    $display("FAIL timeout: simulation did not complete, got running, expected finished");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1);
  end

endmodule
